digit_entry_display: RTL

DIGIT_ENTRY_DISPLAY -- requirements
Module: digit_entry_display

---
 rtl/display_pkg.sv | 42 ++++
 rtl/btn_debounce.sv | 63 ++++++
 rtl/digit_entry_display.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared constants and event-priority encoding for the
//                digit entry / multiplexed display block.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

   // Default dwell time per digit and button settle time, in clock cycles
   localparam int c_default_scan_cycles     = 262144;
   localparam int c_default_debounce_cycles = 1000000;

   // Buffer events, only one of which is acted on per cycle
   typedef enum logic [2:0] {
      EV_NONE  = 3'd0,
      EV_CLEAR = 3'd1,
      EV_KEY   = 3'd2,
      EV_RIGHT = 3'd3,
      EV_LEFT  = 3'd4
   } event_e;

   // Pick the winning event: clear beats key beats right beats left
   function automatic event_e resolve_event(input logic clr,
                                            input logic key,
                                            input logic right,
                                            input logic left);
      event_e ev;
      ev = EV_NONE;
      if (clr)
         ev = EV_CLEAR;
      else if (key)
         ev = EV_KEY;
      else if (right)
         ev = EV_RIGHT;
      else if (left)
         ev = EV_LEFT;
      return ev;
   endfunction

endpackage : display_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchronizer, stable-level debouncer and
//                single-cycle pulse on each accepted press.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
   import display_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = c_default_debounce_cycles
)(
   input  logic clock,
   input  logic reset,
   input  logic i_btn,
   output logic o_pulse
);

   localparam int                 c_cnt_w   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

   logic               r_sync0;
   logic               r_sync1;
   logic               r_stable;
   logic               r_pulse;
   logic [c_cnt_w-1:0] r_count;

   // Bring the raw button into the clock domain; reset means released
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sync0 <= 1'b0;
         r_sync1 <= 1'b0;
      end else begin
         r_sync0 <= i_btn;
         r_sync1 <= r_sync0;
      end
   end

   // Accept a new level only after a full run of equal samples; any sample
   // that matches the old level restarts the run
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_stable <= 1'b0;
         r_count  <= '0;
         r_pulse  <= 1'b0;
      end else begin
         r_pulse <= 1'b0;
         if (r_sync1 == r_stable) begin
            r_count <= '0;
         end else if (r_count == c_cnt_max) begin
            r_count  <= '0;
            r_stable <= r_sync1;
            r_pulse  <= r_sync1;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign o_pulse = r_pulse;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/digit_entry_display.sv
`default_nettype none
// ============================================================================
//  Module      : digit_entry_display
//  Description : Keypad digit entry buffer with cursor buttons and a
//                time-multiplexed, active-low-anode digit scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_entry_display
   import display_pkg::*;
#(
   parameter int NUM_DIGITS      = 4,
   parameter int SCAN_CYCLES     = c_default_scan_cycles,
   parameter int DEBOUNCE_CYCLES = c_default_debounce_cycles,
   parameter int AUTO_WRAP       = 0
)(
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          key_valid,
   input  logic [3:0]                    key_val,
   input  logic                          btnR,
   input  logic                          btnL,
   input  logic                          btnC,
   output logic [NUM_DIGITS-1:0]         anode,
   output logic [3:0]                    hex_out,
   output logic [4*NUM_DIGITS-1:0]       number,
   output logic [$clog2(NUM_DIGITS)-1:0] cursor,
   output logic                          full
);

   localparam int                    c_cur_w     = $clog2(NUM_DIGITS);
   localparam logic [c_cur_w-1:0]    c_cur_last  = c_cur_w'(NUM_DIGITS - 1);
   localparam int                    c_scan_w    = $clog2(SCAN_CYCLES);
   localparam logic [c_scan_w-1:0]   c_scan_max  = c_scan_w'(SCAN_CYCLES - 1);
   localparam logic [NUM_DIGITS-1:0] c_anode_rst = {1'b0, {(NUM_DIGITS-1){1'b1}}};

   logic                    w_right;
   logic                    w_left;
   logic                    w_clear;
   logic                    w_key_ok;
   event_e                  w_event;
   logic [c_cur_w-1:0]      w_cur_inc;
   logic [c_cur_w-1:0]      w_cur_dec;
   logic [NUM_DIGITS-1:0]   w_anode_next;
   logic [3:0]              w_hex_next;

   logic [4*NUM_DIGITS-1:0] r_number;
   logic [c_cur_w-1:0]      r_cursor;
   logic [NUM_DIGITS-1:0]   r_mask;
   logic [c_scan_w-1:0]     r_scan_cnt;
   logic [c_cur_w-1:0]      r_scan_idx;
   logic [NUM_DIGITS-1:0]   r_anode;
   logic [3:0]              r_hex;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_right (
      .clock   (clock),
      .reset   (reset),
      .i_btn   (btnR),
      .o_pulse (w_right)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_left (
      .clock   (clock),
      .reset   (reset),
      .i_btn   (btnL),
      .o_pulse (w_left)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clear (
      .clock   (clock),
      .reset   (reset),
      .i_btn   (btnC),
      .o_pulse (w_clear)
   );

   // Decide this cycle's event and the candidate cursor moves at both ends
   always_comb begin
      w_key_ok = key_valid && (key_val <= 4'd9);
      w_event  = resolve_event(w_clear, w_key_ok, w_right, w_left);

      if (r_cursor == c_cur_last)
         w_cur_inc = (AUTO_WRAP != 0) ? '0 : r_cursor;
      else
         w_cur_inc = r_cursor + 1'b1;

      if (r_cursor == '0)
         w_cur_dec = (AUTO_WRAP != 0) ? c_cur_last : r_cursor;
      else
         w_cur_dec = r_cursor - 1'b1;
   end

   // Entry buffer, cursor and written-slot mask
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_number <= '0;
         r_cursor <= '0;
         r_mask   <= '0;
      end else begin
         case (w_event)
            EV_CLEAR: begin
               r_number <= '0;
               r_cursor <= '0;
               r_mask   <= '0;
            end
            EV_KEY: begin
               for (int k = 0; k < NUM_DIGITS; k++) begin
                  if (r_cursor == c_cur_w'(k)) begin
                     r_number[4*k +: 4] <= key_val;
                     r_mask[k]          <= 1'b1;
                  end
               end
               r_cursor <= w_cur_inc;
            end
            EV_RIGHT: r_cursor <= w_cur_inc;
            EV_LEFT:  r_cursor <= w_cur_dec;
            default:  ;
         endcase
      end
   end

   // Dwell counter and digit index for the display scan
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_scan_cnt <= '0;
         r_scan_idx <= '0;
      end else if (r_scan_cnt == c_scan_max) begin
         r_scan_cnt <= '0;
         r_scan_idx <= (r_scan_idx == c_cur_last) ? '0 : r_scan_idx + 1'b1;
      end else begin
         r_scan_cnt <= r_scan_cnt + 1'b1;
      end
   end

   // Decode the scan index into one low anode bit and the matching slot code
   always_comb begin
      w_anode_next = '1;
      w_hex_next   = 4'h0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (r_scan_idx == c_cur_w'(k)) begin
            w_anode_next[NUM_DIGITS-1-k] = 1'b0;
            w_hex_next                   = r_number[4*k +: 4];
         end
      end
   end

   // Register anode and hex_out together so they switch on the same edge
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_anode <= c_anode_rst;
         r_hex   <= 4'h0;
      end else begin
         r_anode <= w_anode_next;
         r_hex   <= w_hex_next;
      end
   end

   assign anode   = r_anode;
   assign hex_out = r_hex;
   assign number  = r_number;
   assign cursor  = r_cursor;
   assign full    = &r_mask;

endmodule : digit_entry_display
`default_nettype wire
